// File: rtl/scanner_status_monitor_if.sv
// Scanner status bundle: dispatching/evaluating/ready driven by one scanner.
interface i_scanner_status;
   logic dispatching;
   logic evaluating;
   logic ready;

   modport producer (output dispatching, output evaluating, output ready);
   modport consumer (input dispatching, input evaluating, input ready);
endinterface

// File: rtl/scanner_status_monitor.sv
// Turns scanner status strobes into LED drives, a scan phase code and evaluation statistics.
//
// state | meaning
// IDLE  | no scan in progress, dispatching LED off
// SCAN  | scanner dispatching, LED blinking
// FLUSH | dispatch ended, waiting for ready, LED solid
module scanner_status_monitor #(
   parameter int STRETCH_CYCLES = 5_000_000,
   parameter int BLINK_HALF     = 25_000_000,
   parameter int RATE_WINDOW    = 100_000_000,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   i_scanner_status.consumer    status,
   output logic                 led_ready,
   output logic                 led_dispatching,
   output logic                 led_activity,
   output logic [1:0]           phase,
   output logic [CNT_W-1:0]     scan_count,
   output logic [CNT_W-1:0]     eval_rate,
   output logic                 rate_valid,
   output logic                 proto_err
);

   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int WW = $clog2(RATE_WINDOW);

   localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH_CYCLES);
   localparam logic [BW-1:0] BLINK_LD   = BW'(BLINK_HALF - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(RATE_WINDOW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2
   } phase_t;

   phase_t           state;
   logic             d_disp;
   logic             e_eval;
   logic             r_ready;
   logic [BW-1:0]    blink_cnt;
   logic [SW-1:0]    stretch_cnt;
   logic [SW-1:0]    stretch_nxt;
   logic [WW-1:0]    win_cnt;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_sum;

   assign phase = state;

   always_comb begin
      stretch_nxt = stretch_cnt;
      if (e_eval)
         stretch_nxt = STRETCH_LD;
      else if (stretch_cnt != '0)
         stretch_nxt = stretch_cnt - SW'(1);
   end

   always_comb begin
      acc_sum = acc;
      if (e_eval && (acc != '1))
         acc_sum = acc + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         d_disp          <= 1'b0;
         e_eval          <= 1'b0;
         r_ready         <= 1'b0;
         state           <= IDLE;
         led_ready       <= 1'b0;
         led_dispatching <= 1'b0;
         led_activity    <= 1'b0;
         blink_cnt       <= '0;
         stretch_cnt     <= '0;
         scan_count      <= '0;
         win_cnt         <= '0;
         acc             <= '0;
         eval_rate       <= '0;
         rate_valid      <= 1'b0;
         proto_err       <= 1'b0;
      end else begin
         d_disp  <= status.dispatching;
         e_eval  <= status.evaluating;
         r_ready <= status.ready;

         led_ready <= r_ready;

         case (state)
            IDLE: begin
               led_dispatching <= 1'b0;
               if (d_disp) begin
                  state           <= SCAN;
                  led_dispatching <= 1'b1;
                  blink_cnt       <= BLINK_LD;
                  if (scan_count != '1) scan_count <= scan_count + CNT_W'(1);
               end
            end
            SCAN: begin
               if (!d_disp) begin
                  state           <= r_ready ? IDLE : FLUSH;
                  led_dispatching <= !r_ready;
               end else if (blink_cnt == '0) begin
                  led_dispatching <= !led_dispatching;
                  blink_cnt       <= BLINK_LD;
               end else begin
                  blink_cnt <= blink_cnt - BW'(1);
               end
            end
            FLUSH: begin
               led_dispatching <= 1'b1;
               if (d_disp) begin
                  state           <= SCAN;
                  blink_cnt       <= BLINK_LD;
                  if (scan_count != '1) scan_count <= scan_count + CNT_W'(1);
               end else if (r_ready) begin
                  state           <= IDLE;
                  led_dispatching <= 1'b0;
               end
            end
            default: begin
               state           <= IDLE;
               led_dispatching <= 1'b0;
            end
         endcase

         stretch_cnt  <= stretch_nxt;
         led_activity <= (stretch_nxt != '0);

         // A strobe seen on the closing clock belongs to the closing window.
         if (win_cnt == WIN_LAST) begin
            win_cnt    <= '0;
            eval_rate  <= acc_sum;
            rate_valid <= 1'b1;
            acc        <= '0;
         end else begin
            win_cnt    <= win_cnt + WW'(1);
            rate_valid <= 1'b0;
            acc        <= acc_sum;
         end

         if (d_disp && r_ready) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_scanner_status_monitor.sv
// Directed bench for scanner_status_monitor with small timing parameters.
module tb_scanner_status_monitor;

   localparam int CNT_W = 32;

   logic             clk;
   logic             rstn;
   logic             led_ready;
   logic             led_dispatching;
   logic             led_activity;
   logic [1:0]       phase;
   logic [CNT_W-1:0] scan_count;
   logic [CNT_W-1:0] eval_rate;
   logic             rate_valid;
   logic             proto_err;

   int n_checks;
   int n_fail;

   i_scanner_status st ();

   scanner_status_monitor #(
      .STRETCH_CYCLES (4),
      .BLINK_HALF     (3),
      .RATE_WINDOW    (10),
      .CNT_W          (CNT_W)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .status          (st.consumer),
      .led_ready       (led_ready),
      .led_dispatching (led_dispatching),
      .led_activity    (led_activity),
      .phase           (phase),
      .scan_count      (scan_count),
      .eval_rate       (eval_rate),
      .rate_valid      (rate_valid),
      .proto_err       (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      st.dispatching = 1'b0;
      st.evaluating  = 1'b0;
      st.ready       = 1'b0;
      step(2);
      rstn = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn = 1'b0;
      st.dispatching = 1'b0;
      st.evaluating  = 1'b0;
      st.ready       = 1'b0;
      #1;

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         st.dispatching = 1'($urandom_range(0, 1));
         st.evaluating  = 1'($urandom_range(0, 1));
         st.ready       = 1'($urandom_range(0, 1));
         step(1);
      end
      check("rst_led_ready", 32'(led_ready), 0);
      check("rst_led_disp", 32'(led_dispatching), 0);
      check("rst_led_act", 32'(led_activity), 0);
      check("rst_phase", 32'(phase), 0);
      check("rst_scan_count", scan_count, 0);
      check("rst_eval_rate", eval_rate, 0);
      check("rst_rate_valid", 32'(rate_valid), 0);
      check("rst_proto_err", 32'(proto_err), 0);

      // release with ready high: led_ready two clocks later
      rstn = 1'b1;
      st.dispatching = 1'b0;
      st.evaluating  = 1'b0;
      st.ready       = 1'b1;
      step(1);
      check("led_ready_lat1", 32'(led_ready), 0);
      step(1);
      check("led_ready_lat2", 32'(led_ready), 1);

      // scan entry and blink
      st.ready = 1'b0;
      step(2);
      st.dispatching = 1'b1;
      step(1);
      check("scan_pre_phase", 32'(phase), 0);
      step(1);
      check("scan_entry_phase", 32'(phase), 1);
      check("scan_entry_led", 32'(led_dispatching), 1);
      check("scan_count_1", scan_count, 1);
      step(2);
      check("blink_s2", 32'(led_dispatching), 1);
      step(1);
      check("blink_s3", 32'(led_dispatching), 0);
      step(2);
      check("blink_s5", 32'(led_dispatching), 0);
      step(1);
      check("blink_s6", 32'(led_dispatching), 1);
      step(3);
      check("blink_s9", 32'(led_dispatching), 0);

      // drop dispatching with ready low: FLUSH, solid LED
      st.dispatching = 1'b0;
      step(1);
      check("flush_pre_phase", 32'(phase), 1);
      step(1);
      check("flush_phase", 32'(phase), 2);
      check("flush_led", 32'(led_dispatching), 1);
      st.ready = 1'b1;
      step(2);
      check("flush_idle_phase", 32'(phase), 0);
      check("flush_idle_led", 32'(led_dispatching), 0);
      st.ready = 1'b0;
      st.dispatching = 1'b1;
      step(2);
      check("rescan_phase", 32'(phase), 1);
      check("scan_count_2", scan_count, 2);
      st.dispatching = 1'b0;
      step(2);
      st.ready = 1'b1;
      step(2);
      check("back_idle_phase", 32'(phase), 0);
      check("no_proto_err", 32'(proto_err), 0);

      // single strobe stretch
      st.evaluating = 1'b1;
      step(1);
      st.evaluating = 1'b0;
      check("act_k0", 32'(led_activity), 0);
      step(1);
      check("act_k1", 32'(led_activity), 1);
      step(3);
      check("act_k4", 32'(led_activity), 1);
      step(1);
      check("act_k5", 32'(led_activity), 0);

      // retrigger two clocks later: six clocks high, no gap
      st.evaluating = 1'b1;
      step(1);
      st.evaluating = 1'b0;
      step(1);
      check("retrig_k1", 32'(led_activity), 1);
      st.evaluating = 1'b1;
      step(1);
      st.evaluating = 1'b0;
      check("retrig_k2", 32'(led_activity), 1);
      step(1);
      check("retrig_k3", 32'(led_activity), 1);
      step(3);
      check("retrig_k6", 32'(led_activity), 1);
      step(1);
      check("retrig_k7", 32'(led_activity), 0);

      // rate window 1: strobes captured at E2, E5, E9 (E9 is the boundary)
      do_reset();
      step(1);
      st.evaluating = 1'b1;
      step(1);
      st.evaluating = 1'b0;
      step(2);
      st.evaluating = 1'b1;
      step(1);
      st.evaluating = 1'b0;
      step(3);
      check("win1_no_valid_e8", 32'(rate_valid), 0);
      st.evaluating = 1'b1;
      step(1);
      check("win1_no_valid_e9", 32'(rate_valid), 0);
      check("win1_rate_pre", eval_rate, 0);
      step(1);
      check("win1_rate", eval_rate, 3);
      check("win1_valid", 32'(rate_valid), 1);
      step(1);
      check("win1_valid_drop", 32'(rate_valid), 0);
      check("win1_rate_hold", eval_rate, 3);
      // window 2: strobe every clock
      step(8);
      st.evaluating = 1'b0;
      step(1);
      check("win2_rate", eval_rate, 10);
      check("win2_valid", 32'(rate_valid), 1);

      // protocol error and reset mid-scan
      st.ready = 1'b1;
      st.dispatching = 1'b1;
      step(1);
      st.ready = 1'b0;
      st.dispatching = 1'b0;
      step(1);
      check("proto_set", 32'(proto_err), 1);
      step(3);
      check("proto_sticky", 32'(proto_err), 1);
      st.dispatching = 1'b1;
      step(2);
      check("pre_rst_phase", 32'(phase), 1);
      check("pre_rst_scan_count", scan_count, 2);
      check("pre_rst_eval_rate", eval_rate, 10);
      rstn = 1'b0;
      step(1);
      check("midrst_proto", 32'(proto_err), 0);
      check("midrst_scan_count", scan_count, 0);
      check("midrst_eval_rate", eval_rate, 0);
      check("midrst_phase", 32'(phase), 0);
      check("midrst_led_disp", 32'(led_dispatching), 0);
      rstn = 1'b1;
      st.dispatching = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
